uart_tx_rx_module: RTL and testbench

//  Full-duplex single-frame UART: one transmitter and one receiver sharing clock and baud config.

---
 rtl/uart_tx_rx_module.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_tx_rx_module.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_rx_module.sv
// Full-duplex single-frame UART: independent TX and RX engines sharing one
// clock and one baud configuration.
//
// Ports:
//   IN_CLOCK, IN_RESET       clock, synchronous active-high reset
//   IN_TX_LAUNCH, IN_TX_DATA frame request (level) and byte to send
//   OUT_TX_ACTIVE            start bit through last stop bit
//   OUT_TX_DONE              one-clock pulse at frame end
//   OUT_TX_START_BIT_ACTIVE  high during the start bit
//   OUT_TX_STOP_BIT_ACTIVE   high during all stop bits
//   OUT_TX_SERIAL            TX line, idle high
//   IN_RX_SERIAL             RX line, asynchronous
//   OUT_RX_DATA_READY        one-clock pulse per received frame
//   OUT_RX_DATA              last received byte
//   OUT_RX_ERROR             parity or stop-bit error of last frame
module uart_tx_rx_module #(
  parameter int UART_BAUD_RATE           = 9600,
  parameter int CLOCK_FREQUENCY          = 50000000,
  parameter int PARITY                   = 1,
  parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
  parameter int NUMBER_STOP_BITS         = 2
) (
  input  logic                                IN_CLOCK,
  input  logic                                IN_RESET,
  input  logic                                IN_TX_LAUNCH,
  input  logic [NUM_OF_DATA_BITS_IN_PACK-1:0] IN_TX_DATA,
  output logic                                OUT_TX_ACTIVE,
  output logic                                OUT_TX_DONE,
  output logic                                OUT_TX_START_BIT_ACTIVE,
  output logic                                OUT_TX_STOP_BIT_ACTIVE,
  output logic                                OUT_TX_SERIAL,
  input  logic                                IN_RX_SERIAL,
  output logic                                OUT_RX_DATA_READY,
  output logic [NUM_OF_DATA_BITS_IN_PACK-1:0] OUT_RX_DATA,
  output logic                                OUT_RX_ERROR
);

  localparam int N   = NUM_OF_DATA_BITS_IN_PACK;
  localparam int CPB = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(N - 1);
  localparam logic          STOP_LAST = 1'(NUMBER_STOP_BITS - 1);

  // Parity bit that makes data+parity satisfy the configured rule.
  function automatic logic f_par(input logic [N-1:0] d);
    if (PARITY == 2) return ^d;
    return ~^d;
  endfunction

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  tx_state_t         r_tx_state;
  tx_state_t         w_tx_state_n;
  logic [CW-1:0]     r_tx_cnt;
  logic [CW-1:0]     w_tx_cnt_n;
  logic [IW-1:0]     r_tx_idx;
  logic [IW-1:0]     w_tx_idx_n;
  logic              r_tx_stop;
  logic              w_tx_stop_n;
  logic [N-1:0]      r_tx_shift;
  logic [N-1:0]      w_tx_shift_n;
  logic              r_tx_par;
  logic              w_tx_par_n;
  logic              r_tx_serial;
  logic              w_tx_serial_n;
  logic              r_tx_done;
  logic              w_tx_done_n;
  logic              w_tx_end;

  assign w_tx_end = (r_tx_cnt == CPB_LAST);

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      r_tx_state  <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_idx    <= '0;
      r_tx_stop   <= 1'b0;
      r_tx_shift  <= '0;
      r_tx_par    <= 1'b0;
      r_tx_serial <= 1'b1;
      r_tx_done   <= 1'b0;
    end else begin
      r_tx_state  <= w_tx_state_n;
      r_tx_cnt    <= w_tx_cnt_n;
      r_tx_idx    <= w_tx_idx_n;
      r_tx_stop   <= w_tx_stop_n;
      r_tx_shift  <= w_tx_shift_n;
      r_tx_par    <= w_tx_par_n;
      r_tx_serial <= w_tx_serial_n;
      r_tx_done   <= w_tx_done_n;
    end
  end

  always_comb begin
    w_tx_state_n  = r_tx_state;
    w_tx_cnt_n    = r_tx_cnt + 1'b1;
    w_tx_idx_n    = r_tx_idx;
    w_tx_stop_n   = r_tx_stop;
    w_tx_shift_n  = r_tx_shift;
    w_tx_par_n    = r_tx_par;
    w_tx_serial_n = r_tx_serial;
    w_tx_done_n   = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_n    = '0;
        w_tx_serial_n = 1'b1;
        if (IN_TX_LAUNCH) begin
          w_tx_state_n  = TX_START;
          w_tx_shift_n  = IN_TX_DATA;
          w_tx_par_n    = f_par(IN_TX_DATA);
          w_tx_serial_n = 1'b0;
        end
      end
      TX_START: begin
        if (w_tx_end) begin
          w_tx_cnt_n    = '0;
          w_tx_idx_n    = '0;
          w_tx_state_n  = TX_DATA;
          w_tx_serial_n = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        if (w_tx_end) begin
          w_tx_cnt_n = '0;
          if (r_tx_idx == BIT_LAST) begin
            w_tx_stop_n = 1'b0;
            if (PARITY != 0) begin
              w_tx_state_n  = TX_PARITY;
              w_tx_serial_n = r_tx_par;
            end else begin
              w_tx_state_n  = TX_STOP;
              w_tx_serial_n = 1'b1;
            end
          end else begin
            w_tx_idx_n    = r_tx_idx + 1'b1;
            w_tx_shift_n  = r_tx_shift >> 1;
            w_tx_serial_n = r_tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (w_tx_end) begin
          w_tx_cnt_n    = '0;
          w_tx_stop_n   = 1'b0;
          w_tx_state_n  = TX_STOP;
          w_tx_serial_n = 1'b1;
        end
      end
      TX_STOP: begin
        if (w_tx_end) begin
          w_tx_cnt_n = '0;
          if (r_tx_stop == STOP_LAST) begin
            w_tx_state_n = TX_IDLE;
            w_tx_done_n  = 1'b1;
          end else begin
            w_tx_stop_n = 1'b1;
          end
        end
      end
      default: begin
        w_tx_state_n  = TX_IDLE;
        w_tx_serial_n = 1'b1;
      end
    endcase
  end

  assign OUT_TX_SERIAL           = r_tx_serial;
  assign OUT_TX_DONE             = r_tx_done;
  assign OUT_TX_ACTIVE           = (r_tx_state != TX_IDLE);
  assign OUT_TX_START_BIT_ACTIVE = (r_tx_state == TX_START);
  assign OUT_TX_STOP_BIT_ACTIVE  = (r_tx_state == TX_STOP);

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  rx_state_t     r_rx_state;
  rx_state_t     w_rx_state_n;
  logic [CW-1:0] r_rx_cnt;
  logic [CW-1:0] w_rx_cnt_n;
  logic [IW-1:0] r_rx_idx;
  logic [IW-1:0] w_rx_idx_n;
  logic          r_rx_stop;
  logic          w_rx_stop_n;
  logic [N-1:0]  r_rx_shift;
  logic [N-1:0]  w_rx_shift_n;
  logic          r_rx_err;
  logic          w_rx_err_n;
  logic [N-1:0]  r_rx_data;
  logic [N-1:0]  w_rx_data_n;
  logic          r_rx_error;
  logic          w_rx_error_n;
  logic          r_rx_load;
  logic          w_rx_load_n;
  logic          r_rx_ready;
  logic          w_rx_mid;
  logic          w_rx_half;
  logic          w_rx_par_bad;

  assign w_rx_mid  = (r_rx_cnt == CPB_LAST);
  assign w_rx_half = (r_rx_cnt == HALF_LAST);

  // Sampled parity bit vs. accumulated data bits.
  assign w_rx_par_bad = (PARITY == 2) ? (^{r_rx_shift, r_rx_sync})
                                      : (~^{r_rx_shift, r_rx_sync});

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= IN_RX_SERIAL;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_stop  <= 1'b0;
      r_rx_shift <= '0;
      r_rx_err   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_error <= 1'b0;
      r_rx_load  <= 1'b0;
      r_rx_ready <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_cnt   <= w_rx_cnt_n;
      r_rx_idx   <= w_rx_idx_n;
      r_rx_stop  <= w_rx_stop_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_err   <= w_rx_err_n;
      r_rx_data  <= w_rx_data_n;
      r_rx_error <= w_rx_error_n;
      r_rx_load  <= w_rx_load_n;
      r_rx_ready <= r_rx_load;
    end
  end

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt + 1'b1;
    w_rx_idx_n   = r_rx_idx;
    w_rx_stop_n  = r_rx_stop;
    w_rx_shift_n = r_rx_shift;
    w_rx_err_n   = r_rx_err;
    w_rx_data_n  = r_rx_data;
    w_rx_error_n = r_rx_error;
    w_rx_load_n  = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_n = '0;
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_n = RX_START;
        end
      end
      RX_START: begin
        // Half a bit in: still low means a real start bit.
        if (w_rx_half) begin
          w_rx_cnt_n = '0;
          if (!r_rx_sync) begin
            w_rx_state_n = RX_DATA;
            w_rx_idx_n   = '0;
            w_rx_err_n   = 1'b0;
          end else begin
            w_rx_state_n = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (w_rx_mid) begin
          w_rx_cnt_n   = '0;
          w_rx_shift_n = {r_rx_sync, r_rx_shift[N-1:1]};
          if (r_rx_idx == BIT_LAST) begin
            w_rx_stop_n  = 1'b0;
            w_rx_state_n = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            w_rx_idx_n = r_rx_idx + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (w_rx_mid) begin
          w_rx_cnt_n   = '0;
          w_rx_err_n   = w_rx_par_bad;
          w_rx_stop_n  = 1'b0;
          w_rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rx_mid) begin
          w_rx_cnt_n = '0;
          w_rx_err_n = r_rx_err | ~r_rx_sync;
          if (r_rx_stop == STOP_LAST) begin
            // Publish now; READY follows one clock later.
            w_rx_state_n = RX_IDLE;
            w_rx_data_n  = r_rx_shift;
            w_rx_error_n = r_rx_err | ~r_rx_sync;
            w_rx_load_n  = 1'b1;
          end else begin
            w_rx_stop_n = 1'b1;
          end
        end
      end
      default: begin
        w_rx_state_n = RX_IDLE;
      end
    endcase
  end

  assign OUT_RX_DATA_READY = r_rx_ready;
  assign OUT_RX_DATA       = r_rx_data;
  assign OUT_RX_ERROR      = r_rx_error;

endmodule

// File: tb/tb_uart_tx_rx_module.sv
// Bench for uart_tx_rx_module: frame-level TX model, RX scoreboard,
// directed frames at CPB=10, odd parity, two stop bits.
module tb_uart_tx_rx_module;

  localparam int CPB        = 10;
  localparam int FRAME_CLKS = 12 * CPB;
  localparam int STOP_START = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       launch = 1'b0;
  logic [7:0] txd = 8'h00;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx_in;

  logic       tx_act, tx_done, tx_st, tx_sp, tx_ser;
  logic       rx_rdy, rx_err;
  logic [7:0] rx_data;

  assign rx_in = loop ? tx_ser : rx_drv;

  always #5 clk = ~clk;

  uart_tx_rx_module #(
    .UART_BAUD_RATE(100000),
    .CLOCK_FREQUENCY(1000000),
    .PARITY(1),
    .NUM_OF_DATA_BITS_IN_PACK(8),
    .NUMBER_STOP_BITS(2)
  ) dut (
    .IN_CLOCK(clk),
    .IN_RESET(rst),
    .IN_TX_LAUNCH(launch),
    .IN_TX_DATA(txd),
    .OUT_TX_ACTIVE(tx_act),
    .OUT_TX_DONE(tx_done),
    .OUT_TX_START_BIT_ACTIVE(tx_st),
    .OUT_TX_STOP_BIT_ACTIVE(tx_sp),
    .OUT_TX_SERIAL(tx_ser),
    .IN_RX_SERIAL(rx_in),
    .OUT_RX_DATA_READY(rx_rdy),
    .OUT_RX_DATA(rx_data),
    .OUT_RX_ERROR(rx_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Line image of a whole frame, index = bit time.
  function automatic logic [11:0] make_frame(input logic [7:0] d);
    logic [11:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    f[11] = 1'b1;
    return f;
  endfunction

  // TX model: position inside the current frame in clocks, -1 = idle.
  int          tx_pos = -1;
  logic [11:0] tx_frame = '1;
  logic        done_exp = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      tx_pos   <= -1;
      done_exp <= 1'b0;
    end else if (tx_pos >= 0) begin
      tx_pos   <= (tx_pos == FRAME_CLKS - 1) ? -1 : tx_pos + 1;
      done_exp <= (tx_pos == FRAME_CLKS - 1);
    end else begin
      done_exp <= 1'b0;
      if (launch) begin
        tx_pos   <= 0;
        tx_frame <= make_frame(txd);
      end
    end
  end

  function automatic logic [4:0] exp_tx();
    logic l, a, s, p;
    a = (tx_pos >= 0);
    l = a ? tx_frame[tx_pos / CPB] : 1'b1;
    s = a && (tx_pos < CPB);
    p = a && (tx_pos >= STOP_START);
    return {l, a, s, p, done_exp};
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       e;
  } rx_exp_t;

  rx_exp_t q[$];
  int      rdy_count = 0;
  int      done_count = 0;
  logic    prev_rdy = 1'b0;
  bit      chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_outs", {27'd0, tx_ser, tx_act, tx_st, tx_sp, tx_done},
            {27'd0, exp_tx()});
      if (tx_done) done_count <= done_count + 1;
      if (rx_rdy) begin
        rdy_count <= rdy_count + 1;
        check("rdy_width", {31'd0, prev_rdy}, 32'd0);
        check("rdy_expected", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (q.size() > 0) begin
          check("rx_data", {24'd0, rx_data}, {24'd0, q[0].d});
          check("rx_err", {31'd0, rx_err}, {31'd0, q[0].e});
          void'(q.pop_front());
        end
      end
      prev_rdy <= rx_rdy;
    end
  end

  task automatic send_rx(input logic [7:0] d, input logic p,
                         input logic s0, input logic s1);
    logic [11:0] f;
    f = {s1, s0, p, d, 1'b0};
    for (int i = 0; i < 12; i++) begin
      rx_drv = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic e);
    rx_exp_t x;
    x.d = d;
    x.e = e;
    q.push_back(x);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!tx_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(nm, {31'd0, tx_done}, 32'd1);
  endtask

  task automatic wait_active(input string nm);
    int n = 0;
    while (!tx_act && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(nm, {31'd0, tx_act}, 32'd1);
  endtask

  task automatic wait_rdy(input string nm, input int target);
    int n = 0;
    while (rdy_count < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(nm, rdy_count, target);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int sc, pc, done_at, base_done;

    // Model pins
    check("frame_A5", {20'd0, make_frame(8'hA5)}, 32'hF4A);
    check("frame_3C", {20'd0, make_frame(8'h3C)}, 32'hE78);

    // 1: reset held 3 clocks
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_serial", {31'd0, tx_ser}, 32'd1);
    check("rst_flags", {27'd0, tx_act, tx_done, tx_st, tx_sp, rx_rdy},
          32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_err", {31'd0, rx_err}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 2: single 0xA5 frame, data changed after launch
    launch = 1'b1;
    txd = 8'hA5;
    @(negedge clk);
    launch = 1'b0;
    txd = 8'hFF;
    sc = 0;
    pc = 0;
    done_at = -1;
    for (int i = 0; i < 130; i++) begin
      if (tx_st) sc++;
      if (tx_sp) pc++;
      if (tx_done && done_at < 0) done_at = i;
      @(negedge clk);
    end
    check("start_len", sc, 10);
    check("stop_len", pc, 20);
    check("done_at", done_at, 120);

    // Reset in the middle of a frame
    launch = 1'b1;
    txd = 8'h00;
    @(negedge clk);
    launch = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_line", {31'd0, tx_ser}, 32'd1);
    check("abort_active", {31'd0, tx_act}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 3: loopback, launch held over two frames
    loop = 1'b1;
    push_exp(8'h3C, 1'b0);
    push_exp(8'h3C, 1'b0);
    base_done = done_count;
    launch = 1'b1;
    txd = 8'h3C;
    wait_done("loop_done1");
    @(negedge clk);
    wait_active("loop_restart");
    launch = 1'b0;
    wait_done("loop_done2");
    wait_rdy("loop_rdy", 2);
    repeat (20) @(negedge clk);
    check("loop_frames", done_count - base_done, 2);
    check("loop_idle", {31'd0, tx_act}, 32'd0);
    loop = 1'b0;
    repeat (10) @(negedge clk);

    // 4: bad parity
    push_exp(8'h01, 1'b1);
    send_rx(8'h01, 1'b1, 1'b1, 1'b1);
    wait_rdy("par_rdy", 3);

    // 5: first stop bit low, then a clean frame
    push_exp(8'h55, 1'b1);
    send_rx(8'h55, 1'b1, 1'b0, 1'b1);
    push_exp(8'h0F, 1'b0);
    send_rx(8'h0F, 1'b1, 1'b1, 1'b1);
    wait_rdy("stop_rdy", 5);
    repeat (10) @(negedge clk);

    // 6: glitch, then a valid frame
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_rdy", rdy_count, 5);
    push_exp(8'h81, 1'b0);
    send_rx(8'h81, 1'b1, 1'b1, 1'b1);
    wait_rdy("glitch_rdy", 6);

    repeat (50) @(negedge clk);
    check("queue_empty", q.size(), 0);
    check("rdy_total", rdy_count, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
